// File: rtl/mem_stage_lsu_if.sv
// EX->MEM->WB bundle for the load/store stage.
// slave: stage side (EX inputs in, MEM/WB register out); master: driver.
interface mem_stage_lsu_if;
  logic        stall;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        out_valid;
  logic [31:0] wb_data;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        exc_misaligned;
  logic        exc_access;
  logic [31:0] exc_addr;

  modport slave (
    input  stall, in_valid, alu_result,
    input  rs2_data, mem_write, mem_read,
    input  funct3, rd_in, reg_write_in,
    output out_valid, wb_data, rd_out,
    output reg_write_out, exc_misaligned,
    output exc_access, exc_addr
  );

  modport master (
    output stall, in_valid, alu_result,
    output rs2_data, mem_write, mem_read,
    output funct3, rd_in, reg_write_in,
    input  out_valid, wb_data, rd_out,
    input  reg_write_out, exc_misaligned,
    input  exc_access, exc_addr
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I MEM stage: word data memory, byte-lane stores, extended loads.
// Ports: clk, rst (sync, high), bus (EX inputs, registered MEM/WB outputs).
module mem_stage_lsu #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_lsu_if.slave  bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic [31:0] mem [DEPTH];

  logic [31:0] off;
  logic [1:0]  lane;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        mem_op;
  logic        sz_b, sz_h, sz_w;
  logic        bad_f3;
  logic        mis;
  logic        acc;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        sgn;
  logic [31:0] ldata;

  // Unsigned compare of the offset also catches addresses below BASE_ADDR.
  assign off      = bus.alu_result - BASE_ADDR;
  assign lane     = off[1:0];
  assign idx      = off[AW+1:2];
  assign in_range = off < SPAN;

  assign mem_op = bus.in_valid
                & (bus.mem_read | bus.mem_write);

  assign sz_b = bus.funct3[1:0] == 2'b00;
  assign sz_h = bus.funct3[1:0] == 2'b01;
  assign sz_w = bus.funct3 == 3'b010;
  assign sgn  = ~bus.funct3[2];

  assign bad_f3 = (bus.funct3[1:0] == 2'b11)
                | (bus.funct3 == 3'b110)
                | (bus.mem_write & bus.funct3[2])
                | (bus.mem_write & bus.mem_read);

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      sz_h:    mis = lane[0];
      sz_w:    mis = lane != 2'b00;
      default: mis = 1'b0;
    endcase
  end

  assign acc = ~mis & (bad_f3 | ~in_range);

  always_comb begin
    be    = 4'b0000;
    wdata = bus.rs2_data;
    unique case (1'b1)
      sz_b: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.rs2_data[7:0]}};
      end
      sz_h: begin
        be    = 4'b0011 << lane;
        wdata = {2{bus.rs2_data[15:0]}};
      end
      sz_w: begin
        be    = 4'b1111;
        wdata = bus.rs2_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = bus.rs2_data;
      end
    endcase
  end

  assign we = mem_op & bus.mem_write & ~mis & ~acc
            & ~bus.stall & ~rst;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rword = mem[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = rword[{lane[1], 4'b0000} +: 16];

  always_comb begin
    ldata = rword;
    unique case (1'b1)
      sz_b:    ldata = {{24{sgn & rbyte[7]}}, rbyte};
      sz_h:    ldata = {{16{sgn & rhalf[15]}}, rhalf};
      default: ldata = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.wb_data        <= '0;
      bus.rd_out         <= '0;
      bus.reg_write_out  <= 1'b0;
      bus.exc_misaligned <= 1'b0;
      bus.exc_access     <= 1'b0;
      bus.exc_addr       <= '0;
    end else if (!bus.stall) begin
      bus.out_valid      <= bus.in_valid;
      bus.rd_out         <= bus.rd_in;
      bus.exc_misaligned <= mem_op & mis;
      bus.exc_access     <= mem_op & acc;
      bus.exc_addr       <= '0;
      if (!bus.in_valid) begin
        bus.wb_data       <= '0;
        bus.reg_write_out <= 1'b0;
      end else if (mem_op && (mis || acc)) begin
        bus.wb_data       <= '0;
        bus.reg_write_out <= 1'b0;
        bus.exc_addr      <= bus.alu_result;
      end else begin
        bus.wb_data       <= bus.mem_read ? ldata
                                          : bus.alu_result;
        bus.reg_write_out <= bus.reg_write_in;
      end
    end
  end
endmodule
